// File: rtl/rrv2rvh_ruby_pkg.sv
// Shared types and constants for the Ruby-to-RVH store scheduler.
package rrv2rvh_ruby_pkg;

  localparam logic [4:0] ST_OP_SB = 5'd0;
  localparam logic [4:0] ST_OP_SH = 5'd1;
  localparam logic [4:0] ST_OP_SW = 5'd2;
  localparam logic [4:0] ST_OP_SD = 5'd3;

  localparam int unsigned LINE_BYTES  = 64;
  localparam int unsigned LINE_DATA_W = 512;
  localparam int unsigned OFFSET_W    = 6;

  // Entry fields are sized for the widest supported configuration; the
  // scheduler zero-extends narrower addresses/IDs into them.
  localparam int unsigned ST_LPADDR_MAX_W = 64;
  localparam int unsigned ST_ID_MAX_W     = 16;

  typedef struct packed {
    logic [ST_LPADDR_MAX_W-1:0] line_paddr;
    logic [LINE_DATA_W-1:0]     data;
    logic [LINE_BYTES-1:0]      byte_mask;
    logic [ST_ID_MAX_W-1:0]     id;
  } st_entry_t;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } st_sched_state_e;

  function automatic logic [7:0] st_size_mask(input logic [4:0] opcode);
    logic [7:0] m;
    m = '0;
    unique case (opcode)
      ST_OP_SB: m = 8'h01;
      ST_OP_SH: m = 8'h03;
      ST_OP_SW: m = 8'h0F;
      ST_OP_SD: m = 8'hFF;
      default:  m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/rrv2rvh_ruby_st_fifo.sv
// In-order DEPTH-entry queue of translated line stores; exposes the head entry.
module rrv2rvh_ruby_st_fifo
  import rrv2rvh_ruby_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push_i,
  input  st_entry_t push_entry_i,
  input  logic      pop_i,
  output logic      full_o,
  output logic      empty_o,
  output st_entry_t head_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  st_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_i && !pop_i)      cnt_d = cnt_q + 1'b1;
    else if (!push_i && pop_i) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_entry_i;
  end

  assign full_o  = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/rrv2rvh_ruby_st_sched.sv
// Ruby store -> RVH L1D store scheduler: translation, queue, outstanding limit, drain FSM.
// Optional same-cycle bypass of an empty queue: define RRV2RVH_RUBY_ST_BYPASS_EN.
module rrv2rvh_ruby_st_sched
  import rrv2rvh_ruby_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned ID_W      = 4,
  parameter int unsigned PADDR_W   = 56,
  parameter int unsigned MAX_OUTST = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ruby_st_req_vld_i,
  output logic                  ruby_st_req_rdy_o,
  input  logic [PADDR_W-1:0]    ruby_st_req_paddr_i,
  input  logic [63:0]           ruby_st_req_data_i,
  input  logic [4:0]            ruby_st_req_opcode_i,
  input  logic [ID_W-1:0]       ruby_st_req_id_i,
  output logic                  l1d_st_req_vld_o,
  input  logic                  l1d_st_req_rdy_i,
  output logic [PADDR_W-7:0]    l1d_st_req_line_paddr_o,
  output logic [511:0]          l1d_st_req_data_o,
  output logic [63:0]           l1d_st_req_byte_mask_o,
  output logic [ID_W-1:0]       l1d_st_req_id_o,
  input  logic                  l1d_st_resp_vld_i,
  input  logic [ID_W-1:0]       l1d_st_resp_id_i,
  output logic                  ruby_st_resp_vld_o,
  output logic [ID_W-1:0]       ruby_st_resp_id_o,
  input  logic                  flush_req_i,
  output logic                  flush_done_o
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTST);

  st_sched_state_e  state_q, state_d;
  logic [CNT_W-1:0] outst_cnt_q, outst_cnt_d;
  logic             resp_vld_q;
  logic [ID_W-1:0]  resp_id_q;

  st_entry_t        in_entry;
  st_entry_t        head_entry;
  st_entry_t        issue_entry;
  logic [OFFSET_W-1:0] in_off;
  logic             fifo_full, fifo_empty;
  logic             fifo_push, fifo_pop;
  logic             can_issue, bypass, l1d_hs;
  logic             unused_entry_hi;

  // Line translation of the incoming request.
  assign in_off = ruby_st_req_paddr_i[OFFSET_W-1:0];

  always_comb begin
    in_entry            = '0;
    in_entry.line_paddr = ST_LPADDR_MAX_W'(ruby_st_req_paddr_i[PADDR_W-1:OFFSET_W]);
    in_entry.data       = {{(LINE_DATA_W-64){1'b0}}, ruby_st_req_data_i} << {in_off, 3'b000};
    in_entry.byte_mask  = {{(LINE_BYTES-8){1'b0}}, st_size_mask(ruby_st_req_opcode_i)} << in_off;
    in_entry.id         = ST_ID_MAX_W'(ruby_st_req_id_i);
  end

  assign can_issue = (outst_cnt_q < MAX_CNT);

`ifdef RRV2RVH_RUBY_ST_BYPASS_EN
  assign bypass = fifo_empty && (state_q == ST_RUN) && can_issue &&
                  l1d_st_req_rdy_i && ruby_st_req_vld_i;
`else
  assign bypass = 1'b0;
`endif

  assign ruby_st_req_rdy_o = !fifo_full && (state_q == ST_RUN);
  assign fifo_push         = ruby_st_req_vld_i && ruby_st_req_rdy_o && !bypass;
  assign fifo_pop          = !fifo_empty && can_issue && l1d_st_req_rdy_i;

  rrv2rvh_ruby_st_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (fifo_push),
    .push_entry_i (in_entry),
    .pop_i        (fifo_pop),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty),
    .head_o       (head_entry)
  );

  assign issue_entry             = bypass ? in_entry : head_entry;
  assign l1d_st_req_vld_o        = (!fifo_empty && can_issue) || bypass;
  assign l1d_st_req_line_paddr_o = issue_entry.line_paddr[PADDR_W-OFFSET_W-1:0];
  assign l1d_st_req_data_o       = issue_entry.data;
  assign l1d_st_req_byte_mask_o  = issue_entry.byte_mask;
  assign l1d_st_req_id_o         = issue_entry.id[ID_W-1:0];
  assign l1d_hs                  = l1d_st_req_vld_o && l1d_st_req_rdy_i;

  // Upper entry bits are constant zero for narrower configurations.
  assign unused_entry_hi = ^{issue_entry.line_paddr, issue_entry.id};

  // A stray response at zero leaves the count at zero rather than wrapping.
  always_comb begin
    outst_cnt_d = outst_cnt_q;
    if (l1d_hs && !l1d_st_resp_vld_i)
      outst_cnt_d = outst_cnt_q + 1'b1;
    else if (!l1d_hs && l1d_st_resp_vld_i && (outst_cnt_q != '0))
      outst_cnt_d = outst_cnt_q - 1'b1;
  end

  always_comb begin
    state_d      = state_q;
    flush_done_o = 1'b0;
    unique case (state_q)
      ST_RUN:   if (flush_req_i) state_d = ST_DRAIN;
      ST_DRAIN: if (fifo_empty && (outst_cnt_q == '0)) state_d = ST_DONE;
      ST_DONE: begin
        flush_done_o = 1'b1;
        state_d      = ST_RUN;
      end
      default:  state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      outst_cnt_q <= '0;
      resp_vld_q  <= 1'b0;
      resp_id_q   <= '0;
    end else begin
      state_q     <= state_d;
      outst_cnt_q <= outst_cnt_d;
      resp_vld_q  <= l1d_st_resp_vld_i;
      resp_id_q   <= l1d_st_resp_id_i;
    end
  end

  assign ruby_st_resp_vld_o = resp_vld_q;
  assign ruby_st_resp_id_o  = resp_id_q;

`ifndef SYNTHESIS
  resp_without_outstanding : assert property (@(posedge clk) disable iff (!rst_n)
    !(l1d_st_resp_vld_i && (outst_cnt_q == '0)));
`endif

endmodule

// File: tb/tb_rrv2rvh_ruby_st_sched.sv
// Scoreboard bench for rrv2rvh_ruby_st_sched: directed test-plan cases then random traffic.
module tb_rrv2rvh_ruby_st_sched;

  localparam int unsigned DEPTH     = 4;
  localparam int unsigned ID_W      = 4;
  localparam int unsigned PADDR_W   = 56;
  localparam int unsigned MAX_OUTST = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n;
  logic                 ruby_st_req_vld_i;
  logic                 ruby_st_req_rdy_o;
  logic [PADDR_W-1:0]   ruby_st_req_paddr_i;
  logic [63:0]          ruby_st_req_data_i;
  logic [4:0]           ruby_st_req_opcode_i;
  logic [ID_W-1:0]      ruby_st_req_id_i;
  logic                 l1d_st_req_vld_o;
  logic                 l1d_st_req_rdy_i;
  logic [PADDR_W-7:0]   l1d_st_req_line_paddr_o;
  logic [511:0]         l1d_st_req_data_o;
  logic [63:0]          l1d_st_req_byte_mask_o;
  logic [ID_W-1:0]      l1d_st_req_id_o;
  logic                 l1d_st_resp_vld_i;
  logic [ID_W-1:0]      l1d_st_resp_id_i;
  logic                 ruby_st_resp_vld_o;
  logic [ID_W-1:0]      ruby_st_resp_id_o;
  logic                 flush_req_i;
  logic                 flush_done_o;

  rrv2rvh_ruby_st_sched #(
    .DEPTH(DEPTH), .ID_W(ID_W), .PADDR_W(PADDR_W), .MAX_OUTST(MAX_OUTST)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ruby_st_req_vld_i(ruby_st_req_vld_i), .ruby_st_req_rdy_o(ruby_st_req_rdy_o),
    .ruby_st_req_paddr_i(ruby_st_req_paddr_i), .ruby_st_req_data_i(ruby_st_req_data_i),
    .ruby_st_req_opcode_i(ruby_st_req_opcode_i), .ruby_st_req_id_i(ruby_st_req_id_i),
    .l1d_st_req_vld_o(l1d_st_req_vld_o), .l1d_st_req_rdy_i(l1d_st_req_rdy_i),
    .l1d_st_req_line_paddr_o(l1d_st_req_line_paddr_o), .l1d_st_req_data_o(l1d_st_req_data_o),
    .l1d_st_req_byte_mask_o(l1d_st_req_byte_mask_o), .l1d_st_req_id_o(l1d_st_req_id_o),
    .l1d_st_resp_vld_i(l1d_st_resp_vld_i), .l1d_st_resp_id_i(l1d_st_resp_id_i),
    .ruby_st_resp_vld_o(ruby_st_resp_vld_o), .ruby_st_resp_id_o(ruby_st_resp_id_o),
    .flush_req_i(flush_req_i), .flush_done_o(flush_done_o)
  );

  typedef struct {
    logic [PADDR_W-7:0] lp;
    logic [511:0]       d;
    logic [63:0]        m;
    logic [ID_W-1:0]    id;
  } exp_t;
  typedef struct {
    logic [ID_W-1:0] id;
    int              cyc;
  } rsp_t;
  typedef enum {M_RUN, M_DRAIN, M_DONE} mst_e;

  exp_t            exp_q[$];     // accepted stores, in order (driver pushes)
  rsp_t            resp_exp[$];  // responses driven into the DUT (driver pushes)
  logic [ID_W-1:0] issued_q[$];  // IDs seen leaving on the L1D port (monitor pushes)

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Driver-owned state
  logic acc_now = 1'b0, was_acc = 1'b0;
  logic chk_en = 1'b0, end_chk = 1'b0;
  logic rand_mode = 1'b0, resp_en = 1'b0;
  int   resp_pct = 100;
  int   tmo_events = 0;

  // Monitor-owned state
  int   n_vec = 0, n_err = 0;
  int   rd_idx = 0, ri = 0;
  logic first_chk = 1'b1, end_done = 1'b0;
  mst_e mstate = M_RUN;
  int   m_pending, m_applied, m_outst;
  logic m_exp_vld;
  exp_t m_e;

  // Expected line store, built byte by byte from the opcode size rules.
  function automatic exp_t model(input logic [4:0] op, input logic [PADDR_W-1:0] pa,
                                 input logic [63:0] d, input logic [ID_W-1:0] id);
    exp_t e;
    int   off, sz;
    e.lp = pa[PADDR_W-1:6];
    e.d  = '0;
    e.m  = '0;
    e.id = id;
    off  = int'(pa[5:0]);
    case (op)
      5'd0: sz = 1;
      5'd1: sz = 2;
      5'd2: sz = 4;
      5'd3: sz = 8;
      default: sz = 0;
    endcase
    for (int b = 0; b < 64; b++) begin
      if (b >= off && b < off + 8) e.d[b*8 +: 8] = d[(b-off)*8 +: 8];
      if (b >= off && b < off + sz) e.m[b] = 1'b1;
    end
    return e;
  endfunction

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h required %0h", nm, cyc, act, req);
    end
  endtask

  // Monitor: everything is compared here, half a cycle away from the active edge.
  always @(negedge clk) begin
    #1;
    if (chk_en) begin
      m_pending = exp_q.size() - rd_idx - (acc_now ? 1 : 0);
      m_applied = resp_exp.size();
      if (m_applied > 0 && resp_exp[m_applied-1].cyc == cyc) m_applied--;
      m_outst   = issued_q.size() - m_applied;
      m_exp_vld = (m_pending > 0) && (m_outst < int'(MAX_OUTST));
`ifdef RRV2RVH_RUBY_ST_BYPASS_EN
      m_exp_vld = m_exp_vld || (m_pending == 0 && mstate == M_RUN && m_outst < int'(MAX_OUTST) &&
                                l1d_st_req_rdy_i && ruby_st_req_vld_i);
`endif
      chk("l1d_vld", l1d_st_req_vld_o, m_exp_vld);
      if (l1d_st_req_vld_o && rd_idx < exp_q.size()) begin
        m_e = exp_q[rd_idx];
        chk("line_paddr", l1d_st_req_line_paddr_o, m_e.lp);
        chk("byte_mask", l1d_st_req_byte_mask_o, m_e.m);
        chk("data", l1d_st_req_data_o, m_e.d);
        chk("req_id", l1d_st_req_id_o, m_e.id);
        if (l1d_st_req_rdy_i) begin
          issued_q.push_back(m_e.id);
          rd_idx++;
        end
      end
      chk("ruby_rdy", ruby_st_req_rdy_o, (m_pending < int'(DEPTH)) && (mstate == M_RUN));
      chk("flush_done", flush_done_o, mstate == M_DONE);
      if (ri < resp_exp.size() && resp_exp[ri].cyc + 1 == cyc) begin
        chk("resp_vld", ruby_st_resp_vld_o, 1'b1);
        chk("resp_id", ruby_st_resp_id_o, resp_exp[ri].id);
        ri++;
      end else begin
        chk("resp_vld", ruby_st_resp_vld_o, 1'b0);
      end
      if (first_chk) begin
        chk("reset_resp_id", ruby_st_resp_id_o, '0);
        first_chk = 1'b0;
      end
      case (mstate)
        M_RUN:   if (flush_req_i) mstate = M_DRAIN;
        M_DRAIN: if (m_pending == 0 && m_outst == 0) mstate = M_DONE;
        default: mstate = M_RUN;
      endcase
      if (end_chk && !end_done) begin
        chk("timeouts", tmo_events, 0);
        chk("undrained_reqs", exp_q.size() - rd_idx, 0);
        chk("missing_resps", resp_exp.size() - ri, 0);
        end_done = 1'b1;
      end
    end
  end

  task automatic drive_req(input logic [4:0] op, input logic [PADDR_W-1:0] pa,
                           input logic [63:0] d, input logic [ID_W-1:0] id);
    ruby_st_req_vld_i    = 1'b1;
    ruby_st_req_opcode_i = op;
    ruby_st_req_paddr_i  = pa;
    ruby_st_req_data_i   = d;
    ruby_st_req_id_i     = id;
  endtask

  // One clock: record an acceptance at the negedge, then drive the next inputs.
  task automatic cycle();
    logic [63:0] r64;
    logic [63:0] rd;
    @(negedge clk);
    acc_now = ruby_st_req_vld_i && ruby_st_req_rdy_o;
    if (acc_now)
      exp_q.push_back(model(ruby_st_req_opcode_i, ruby_st_req_paddr_i,
                            ruby_st_req_data_i, ruby_st_req_id_i));
    @(posedge clk);
    #1;
    was_acc = acc_now;
    acc_now = 1'b0;
    if (was_acc) ruby_st_req_vld_i = 1'b0;
    l1d_st_resp_vld_i = 1'b0;
    if (resp_en && resp_exp.size() < issued_q.size() && int'($urandom_range(99)) < resp_pct) begin
      l1d_st_resp_vld_i = 1'b1;
      l1d_st_resp_id_i  = issued_q[resp_exp.size()];
      resp_exp.push_back('{id: l1d_st_resp_id_i, cyc: cyc});
    end
    if (rand_mode) begin
      l1d_st_req_rdy_i = ($urandom_range(99) < 70);
      flush_req_i      = ($urandom_range(99) < 4);
      if (!ruby_st_req_vld_i && $urandom_range(99) < 60) begin
        r64 = {$urandom(), $urandom()};
        rd  = {$urandom(), $urandom()};
        drive_req(5'($urandom_range(7)), r64[PADDR_W-1:0], rd, ID_W'($urandom_range(15)));
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wait_acc(input int limit);
    int n;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!was_acc && n < limit);
    if (!was_acc) begin
      tmo_events++;
      $display("FAIL accept_timeout @cyc %0d: got no accept required accept", cyc);
      ruby_st_req_vld_i = 1'b0;
    end
  endtask

  task automatic send(input logic [4:0] op, input logic [PADDR_W-1:0] pa,
                      input logic [63:0] d, input logic [ID_W-1:0] id);
    drive_req(op, pa, d, id);
    wait_acc(200);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    ruby_st_req_vld_i = 1'b0;
    ruby_st_req_paddr_i = '0;
    ruby_st_req_data_i = '0;
    ruby_st_req_opcode_i = '0;
    ruby_st_req_id_i = '0;
    l1d_st_req_rdy_i = 1'b0;
    l1d_st_resp_vld_i = 1'b0;
    l1d_st_resp_id_i = '0;
    flush_req_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    chk_en = 1'b1;
    resp_en = 1'b1;
    resp_pct = 100;
    l1d_st_req_rdy_i = 1'b1;

    // Line translation cases, including a store running off the end of the line
    send(5'd2, 56'h1004, 64'hDEADBEEF, 4'd1);
    idle(4);
    send(5'd3, 56'h2003C, 64'h1122334455667788, 4'd2);
    idle(4);
    send(5'd9, 56'h7005, 64'hCAFEF00D12345678, 4'd3);
    send(5'd0, 56'h7, 64'h00000000000000A5, 4'd4);
    idle(4);

    // Backpressure: fill the queue, fifth store waits for space
    l1d_st_req_rdy_i = 1'b0;
    for (int i = 0; i < 4; i++)
      send(5'(i), 56'h3000 + 56'(i * 9), {$urandom(), $urandom()}, 4'(i));
    drive_req(5'd0, 56'h4000, 64'h55, 4'd4);
    idle(3);
    l1d_st_req_rdy_i = 1'b1;
    wait_acc(100);
    idle(10);

    // Outstanding limit with responses held back
    resp_en = 1'b0;
    for (int i = 0; i < 4; i++)
      send(5'd1, 56'h5000 + 56'(i * 2), {$urandom(), $urandom()}, 4'(i + 8));
    idle(5);
    resp_en = 1'b1;
    idle(10);

    // Drain with one store outstanding and three queued
    resp_en = 1'b0;
    send(5'd2, 56'h6000, 64'h0BADC0DE, 4'd12);
    l1d_st_req_rdy_i = 1'b0;
    for (int i = 0; i < 3; i++)
      send(5'd3, 56'h6040 + 56'(i * 64), {$urandom(), $urandom()}, 4'(13 + i));
    flush_req_i = 1'b1;
    cycle();
    flush_req_i = 1'b0;
    idle(3);
    l1d_st_req_rdy_i = 1'b1;
    resp_en = 1'b1;
    idle(12);

    // Immediate drain with nothing pending
    flush_req_i = 1'b1;
    cycle();
    flush_req_i = 1'b0;
    idle(4);

    // Random traffic
    resp_pct  = 50;
    rand_mode = 1'b1;
    idle(1500);
    rand_mode = 1'b0;
    flush_req_i = 1'b0;
    l1d_st_req_rdy_i = 1'b1;
    resp_pct = 100;
    n = 0;
    while (n < 400 && (ruby_st_req_vld_i || rd_idx != exp_q.size() ||
                       resp_exp.size() != issued_q.size() || ri != resp_exp.size())) begin
      cycle();
      n++;
    end
    if (n >= 400) begin
      tmo_events++;
      $display("FAIL drain_timeout @cyc %0d: got still busy required idle", cyc);
    end
    idle(3);

    end_chk = 1'b1;
    n = 0;
    while (!end_done && n < 10) begin
      cycle();
      n++;
    end
    if (!end_done) begin
      $display("FAIL end_check @cyc %0d: got not run required run", cyc);
      $fatal(1, "end check did not run");
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
